pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed MEM/WB-style pipeline register.
- N-deep elastic pipeline of payload registers, each stage with its own valid bit.
- Valid/ready handshake on both sides, bubble-collapsing stall propagation, synchronous flush.
- Used between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB), including multi-cycle retiming slices; control and data fields are packed into one payload by the instantiating stage.

Parameters:
- DATA_WIDTH, 32, payload width in bits (packed control + data fields); must be >= 1
- STAGES, 1, number of register stages; must be >= 1
- CNT_WIDTH, $clog2(STAGES+1), width of the occupancy counter (derived; do not override)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- flush  in  1  synchronous flush; invalidates every stage
- in_valid  in  1  upstream has a payload
- in_ready  out  1  stage 0 can accept this cycle
- in_data  in  DATA_WIDTH  upstream payload
- out_valid  out  1  last stage holds a valid payload
- out_ready  in  1  downstream accepts this cycle
- out_data  out  DATA_WIDTH  payload of the last stage
- occupancy  out  CNT_WIDTH  number of valid stages, 0..STAGES

Behaviour:
- State per stage i (0 = input side, STAGES-1 = output side): v[i] and d[i].
- Reset (rst_n low, asynchronous): all v[i]=0 and occupancy=0. This gives out_valid=0 and in_ready=1, provided flush=0.
- Reset asserted mid-transfer drops all in-flight payloads. No partial handshake survives.
- Advance terms, combinational:
  - adv[STAGES-1] = !v[STAGES-1] | out_ready
  - adv[i] = !v[i] | adv[i+1]
  - A bubble anywhere downstream lets all upstream stages move (bubble-collapsing).
- in_ready = adv[0] & !flush.
- Stage load on rising edge when adv[i]=1:
  - v[0] <= in_valid & in_ready, d[0] <= in_data
  - v[i] <= v[i-1], d[i] <= d[i-1]
- Stage i with adv[i]=0 holds both v and d.
- out_valid = v[STAGES-1], out_data = d[STAGES-1]. Both are direct register outputs, with no combinational path from in_* to out_*.
- in_ready does have a combinational path from out_ready, through the adv chain.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out_data is held stable while out_valid=1 and out_ready=0.
- Latency: a payload accepted in cycle k is presented on out_* in cycle k+STAGES when no stall occurs.
- Throughput: 1 payload/cycle with out_ready held high.
- Flush (synchronous, highest priority over loads):
  - in_ready=0 in the flush cycle, so nothing is accepted.
  - An output transfer in the flush cycle (out_valid & out_ready) completes normally.
  - At the edge, all v[i] <= 0 and occupancy <= 0.
  - flush held high keeps the pipe empty.
- occupancy (registered):
  - +1 on input transfer only.
  - -1 on output transfer only.
  - Unchanged on both or neither.
  - Forced to 0 on flush.
  - Invariant: occupancy == popcount(v) at every edge.
- Full: occupancy=STAGES and out_ready=0 gives in_ready=0.
- Full with out_ready=1: in_ready=1, and simultaneous in/out transfers keep occupancy=STAGES.
- Empty: out_valid=0. With flush=0, in_ready=1 regardless of out_ready.
- Data registers carry no reset unless PIPE_CLEAR_DATA_EN is defined.

Optional Feature:
- Macro: PIPE_CLEAR_DATA_EN
- Defined:
  - d[i] reset asynchronously to 0 on rst_n low.
  - d[i] cleared to 0 on flush.
  - d[i] cleared to 0 when stage i is loaded with v=0 (bubble).
  - out_data therefore reads 0 whenever out_valid=0; this guarantees no stale RegWrite/MemWrite bits leak downstream.
- Undefined:
  - d[i] has no reset and is loaded only when the incoming v=1; bubbles hold the previous value.
  - out_data is don't-care while out_valid=0. Handshake, latency and occupancy are identical either way.

Test Plan:
- Reset and streaming, STAGES=3, out_ready=1:
  - Hold rst_n low -> out_valid=0, in_ready=1, occupancy=0.
  - Release, drive in_data 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 in cycles 3,4,5 after the first accept.
  - occupancy settles at 3, then falls to 0.
- Backpressure, STAGES=2:
  - Fill with 0xA0,0xA1 while out_ready=0 -> occupancy=2, in_ready=0, out_data stable at 0xA0 for 5 cycles.
  - Raise out_ready -> 0xA0 then 0xA1 delivered, no loss or duplication.
- Bubble collapse, STAGES=3:
  - Stages hold {valid, empty, valid}, out_ready=0, in_valid=1 -> in_ready=1.
  - After one edge: occupancy=3, out_data unchanged.
- Flush with simultaneous output, STAGES=2, full:
  - flush=1, out_ready=1, in_valid=1 -> in_ready=0 that cycle, the output transfer completes, next cycle out_valid=0 and occupancy=0.
  - In-flight 0x55 never appears on out_data.
- Asynchronous reset mid-stream:
  - Assert rst_n low between clock edges with occupancy=2 -> out_valid drops immediately (before the next edge) and occupancy=0.
- PIPE_CLEAR_DATA_EN:
  - Defined: insert a bubble between 0xFFFFFFFF payloads -> out_data=0 during the bubble cycle.
  - Undefined: out_data holds 0xFFFFFFFF during the bubble, with out_valid=0.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// N-deep elastic valid/ready pipeline with bubble collapsing, synchronous flush and occupancy count.
// Optional macro PIPE_CLEAR_DATA_EN: data registers reset, flush-clear and bubble-clear to zero.
module pipe_stage_elastic #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STAGES     = 1,
  parameter int unsigned CNT_WIDTH  = $clog2(STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  occupancy
);

  logic [STAGES-1:0]     v_q, v_d, adv;
  logic [DATA_WIDTH-1:0] d_q [STAGES];
  logic [DATA_WIDTH-1:0] d_d [STAGES];
  logic [STAGES:0]       v_src;
  logic [DATA_WIDTH-1:0] d_src [STAGES+1];
  logic [CNT_WIDTH-1:0]  occ_q, occ_d;
  logic                  in_xfer, out_xfer;

  // adv[i] = out_ready | any bubble at or beyond stage i, built with an
  // accumulator so the chain carries no self-referencing vector.
  always_comb begin : adv_chain
    logic acc;
    acc = out_ready;
    adv = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      acc = acc | ~v_q[STAGES-1-k];
      adv[STAGES-1-k] = acc;
    end
  end

  assign in_ready  = adv[0] & ~flush;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = v_q[STAGES-1] & out_ready;
  assign out_valid = v_q[STAGES-1];
  assign out_data  = d_q[STAGES-1];
  assign occupancy = occ_q;

  always_comb begin : next_state
    v_src    = {v_q, in_xfer};
    d_src[0] = in_data;
    for (int unsigned k = 0; k < STAGES; k++) begin
      d_src[k+1] = d_q[k];
    end
    v_d = v_q;
    for (int unsigned k = 0; k < STAGES; k++) begin
      d_d[k] = d_q[k];
      if (adv[k]) begin
        v_d[k] = v_src[k];
`ifdef PIPE_CLEAR_DATA_EN
        d_d[k] = v_src[k] ? d_src[k] : '0;
`else
        if (v_src[k]) begin
          d_d[k] = d_src[k];
        end
`endif
      end
    end
    if (flush) begin
      v_d = '0;
`ifdef PIPE_CLEAR_DATA_EN
      for (int unsigned k = 0; k < STAGES; k++) begin
        d_d[k] = '0;
      end
`endif
    end
  end

  always_comb begin : occ_next
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (in_xfer && !out_xfer) begin
      occ_d = occ_q + CNT_WIDTH'(1);
    end else if (out_xfer && !in_xfer) begin
      occ_d = occ_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
    end
  end

`ifdef PIPE_CLEAR_DATA_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      d_q[k] <= d_d[k];
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: u0 has STAGES=3, u1 has STAGES=2.
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fl0, iv0, or0, fl1, iv1, or1;
  logic [31:0] id0, id1;
  logic        ir0, ov0, ir1, ov1;
  logic [31:0] od0, od1;
  logic [1:0]  oc0, oc1;

  int checks = 0;
  int errors = 0;
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_WIDTH(32), .STAGES(3)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(fl0),
    .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .occupancy(oc0)
  );

  pipe_stage_elastic #(.DATA_WIDTH(32), .STAGES(2)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(fl1),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(oc1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: an output transfer is visible at the negedge before the edge that completes it.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ov0 && or0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL u0_unexpected_out act=%0h exp=none t=%0t", od0, $time);
        end else begin
          check("u0_out_data", od0, q0.pop_front());
        end
      end
      if (ov1 && or1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL u1_unexpected_out act=%0h exp=none t=%0t", od1, $time);
        end else begin
          check("u1_out_data", od1, q1.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    {fl0, iv0, fl1, iv1} = '0;
    or0 = 1'b1; or1 = 1'b1;
    id0 = '0; id1 = '0;

    // Reset state
    neg();
    check("rst_ov0", ov0, 0); check("rst_ir0", ir0, 1); check("rst_oc0", oc0, 0);
    check("rst_ov1", ov1, 0); check("rst_ir1", ir1, 1); check("rst_oc1", oc1, 0);
    tick(); rst_n = 1'b1;

    // Streaming, STAGES=3, out_ready=1
    iv0 = 1; id0 = 32'h11; neg(); check("s_ir", ir0, 1); q0.push_back(32'h11); check("s_oc0", oc0, 0);
    tick(); id0 = 32'h22; neg(); q0.push_back(32'h22); check("s_oc1", oc0, 1); check("s_ov1", ov0, 0);
    tick(); id0 = 32'h33; neg(); q0.push_back(32'h33); check("s_oc2", oc0, 2); check("s_ov2", ov0, 0);
    tick(); iv0 = 0; neg(); check("s_lat_ov", ov0, 1); check("s_oc3", oc0, 3);
    tick(); neg(); check("s_oc4", oc0, 2); check("s_ov4", ov0, 1);
    tick(); neg(); check("s_oc5", oc0, 1);
    tick(); neg(); check("s_oc6", oc0, 0); check("s_ov6", ov0, 0);

    // Backpressure, STAGES=2
    tick(); or1 = 0; iv1 = 1; id1 = 32'hA0; neg(); check("bp_ir0", ir1, 1); q1.push_back(32'hA0);
    tick(); id1 = 32'hA1; neg(); check("bp_ir1", ir1, 1); q1.push_back(32'hA1);
    tick(); id1 = 32'hA2; neg(); check("bp_oc", oc1, 2); check("bp_ir_full", ir1, 0);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_data", od1, 32'hA0); check("bp_hold_ov", ov1, 1); check("bp_hold_ir", ir1, 0);
      tick(); neg();
    end
    tick(); iv1 = 0; or1 = 1; neg();
    tick(); neg(); check("bp_oc_a", oc1, 1);
    tick(); neg(); check("bp_oc_b", oc1, 0); check("bp_ov_b", ov1, 0);

    // Full with out_ready=1: simultaneous transfers keep occupancy at STAGES
    tick(); or1 = 0; iv1 = 1; id1 = 32'hB0; neg(); q1.push_back(32'hB0);
    tick(); id1 = 32'hB1; neg(); q1.push_back(32'hB1);
    tick(); or1 = 1; id1 = 32'hB2; neg(); check("fr_ir2", ir1, 1); check("fr_oc2", oc1, 2); q1.push_back(32'hB2);
    tick(); id1 = 32'hB3; neg(); check("fr_ir3", ir1, 1); check("fr_oc3", oc1, 2); q1.push_back(32'hB3);
    tick(); iv1 = 0; neg(); check("fr_oc4", oc1, 2);
    tick(); neg(); check("fr_oc5", oc1, 1);
    tick(); or1 = 0; neg(); check("empty_oc", oc1, 0); check("empty_ov", ov1, 0); check("empty_ir", ir1, 1);

    // Bubble collapse, STAGES=3: build {valid, empty, valid} with out_ready=0
    tick(); or0 = 0; iv0 = 1; id0 = 32'h31; neg(); q0.push_back(32'h31);
    tick(); iv0 = 0; neg();
    tick(); neg();
    tick(); iv0 = 1; id0 = 32'h32; neg(); q0.push_back(32'h32); check("bc_oc1", oc0, 1);
    tick(); id0 = 32'h33; neg(); check("bc_ir", ir0, 1); check("bc_oc2", oc0, 2); q0.push_back(32'h33);
    tick(); iv0 = 0; neg(); check("bc_oc3", oc0, 3); check("bc_data", od0, 32'h31); check("bc_ir_full", ir0, 0);
    tick(); or0 = 1;
    repeat (4) begin tick(); end
    neg(); check("bc_drain_oc", oc0, 0);

    // Flush with simultaneous output, STAGES=2 full
    tick(); or1 = 0; iv1 = 1; id1 = 32'h54; neg(); q1.push_back(32'h54);
    tick(); id1 = 32'h55; neg(); q1.push_back(32'h55);
    tick(); fl1 = 1; or1 = 1; id1 = 32'h56; neg(); check("fl_ir", ir1, 0);
    #1 q1.delete();
    tick(); neg(); check("fl_ov", ov1, 0); check("fl_oc", oc1, 0); check("fl_hold_ir", ir1, 0);
    tick(); fl1 = 0; iv1 = 0; neg(); check("fl_ov2", ov1, 0); check("fl_oc2", oc1, 0); check("fl_ir2", ir1, 1);
    repeat (3) begin tick(); end

    // Asynchronous reset mid-stream
    or1 = 0; iv1 = 1; id1 = 32'h61; neg(); q1.push_back(32'h61);
    tick(); id1 = 32'h62; neg(); q1.push_back(32'h62);
    tick(); iv1 = 0; neg(); check("ar_oc_pre", oc1, 2); check("ar_ov_pre", ov1, 1);
    #2 rst_n = 1'b0;
    #1 check("ar_ov", ov1, 0); check("ar_oc", oc1, 0);
    q1.delete();
    tick(); rst_n = 1'b1; or1 = 1;

    // Bubble between all-ones payloads
    tick(); or0 = 1; iv0 = 1; id0 = 32'hFFFF_FFFF; neg(); q0.push_back(32'hFFFF_FFFF);
    tick(); iv0 = 0; neg();
    tick(); iv0 = 1; neg(); q0.push_back(32'hFFFF_FFFF);
    tick(); iv0 = 0; neg(); check("cd_ov_a", ov0, 1);
    tick(); neg(); check("cd_ov_bubble", ov0, 0);
`ifdef PIPE_CLEAR_DATA_EN
    check("cd_data_bubble", od0, 32'h0);
`else
    check("cd_data_bubble", od0, 32'hFFFF_FFFF);
`endif
    tick(); neg(); check("cd_ov_b", ov0, 1);
    repeat (4) begin tick(); end

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
